// File: rtl/uart_rx_deserializer_if.sv
// Parallel-side and serial-side signals of the UART receive front end.
interface uart_rx_deserializer_if #(
  parameter int DATA_SIZE = 7
);
  logic                 rx;
  logic                 data_read_ack;
  logic [DATA_SIZE-1:0] d_o;
  logic                 data_ready;
  logic                 frame_error;
  logic                 overrun;
  logic                 busy;

  // Environment side: drives the line and the acknowledge, consumes the word.
  modport master (
    output rx,
    output data_read_ack,
    input  d_o,
    input  data_ready,
    input  frame_error,
    input  overrun,
    input  busy
  );

  // Receiver side.
  modport slave (
    input  rx,
    input  data_read_ack,
    output d_o,
    output data_ready,
    output frame_error,
    output overrun,
    output busy
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: 2-FF synchroniser, start-edge referenced oversample
// timing, LSB-first deserialisation, stop-bit check and ready/ack handshake.
module uart_rx_deserializer #(
  parameter int DATA_SIZE  = 7,
  parameter int OVERSAMPLE = 16,
  parameter int CLK_DIV    = 27
) (
  input  logic                   clk,
  input  logic                   res,
  uart_rx_deserializer_if.slave  bus
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TCK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [TCK_W-1:0] TCK_MID  = TCK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TCK_W-1:0] TCK_LAST = TCK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_SIZE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q, rx_s;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [TCK_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_SIZE-1:0] sh_q, sh_d;
  logic [DATA_SIZE-1:0] d_q;
  logic                 ready_q, ferr_q, ovr_q;
  logic                 tick, mid_hit, bit_hit;
  logic                 shift_en, frame_done;

  // Two-flop synchroniser, preset to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (res) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s    = sync2_q;
  assign tick    = (state_q != IDLE) && (div_q == DIV_LAST);
  assign mid_hit = tick && (tick_cnt_q == TCK_MID);
  assign bit_hit = tick && (tick_cnt_q == TCK_LAST);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (res) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_s) state_d = START;
      START:   if (mid_hit) state_d = rx_s ? IDLE : DATA;
      DATA:    if (bit_hit && (bit_cnt_q == BIT_LAST)) state_d = STOP;
      STOP:    if (bit_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output decode: data-bit sample strobe and frame-complete strobe.
  always_comb begin
    shift_en   = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      DATA:    shift_en   = bit_hit;
      STOP:    frame_done = bit_hit;
      default: ;
    endcase
  end

  assign bus.busy = (state_q != IDLE);

  // Timing counters and shift register next state; the divider idles at 0
  // so the first tick phase is locked to the detected start edge.
  always_comb begin
    if (state_q == IDLE || div_q == DIV_LAST) div_d = '0;
    else                                      div_d = div_q + 1'b1;

    tick_cnt_d = tick_cnt_q;
    if (state_d != state_q) tick_cnt_d = '0;
    else if (tick)          tick_cnt_d = (tick_cnt_q == TCK_LAST) ? '0 : tick_cnt_q + 1'b1;

    bit_cnt_d = bit_cnt_q;
    if (state_q != DATA) bit_cnt_d = '0;
    else if (shift_en)   bit_cnt_d = bit_cnt_q + 1'b1;

    sh_d = shift_en ? {rx_s, sh_q[DATA_SIZE-1:1]} : sh_q;
  end

  // Timing counters and shift register.
  always_ff @(posedge clk) begin
    if (res) begin
      div_q      <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      sh_q       <= '0;
    end else begin
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
    end
  end

  // Output word and handshake; a completing frame takes priority over an ack.
  always_ff @(posedge clk) begin
    if (res) begin
      d_q     <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (frame_done) begin
        d_q     <= sh_q;
        ready_q <= 1'b1;
        if (rx_s) begin
          ferr_q <= 1'b0;
          ovr_q  <= ready_q && !ferr_q && !bus.data_read_ack;
        end else begin
          ferr_q <= 1'b1;
        end
      end else if (ferr_q) begin
        ready_q <= 1'b0;
        ferr_q  <= 1'b0;
      end else if (ready_q && bus.data_read_ack) begin
        ready_q <= 1'b0;
      end
    end
  end

  assign bus.d_o         = d_q;
  assign bus.data_ready  = ready_q;
  assign bus.frame_error = ferr_q;
  assign bus.overrun     = ovr_q;
endmodule
